condicionador_botoes: RTL and testbench

Input conditioning stage placed directly upstream of the game datapath/control unit (`circuito_exp7`). It synchronizes, debounces and validates the four raw `botoes` inputs, then issues exactly one single-cycle `jogada` pulse per physical press, carrying a latched one-hot code of the pressed button. Presses are never repeated while a button is held, and multi-button presses are rejected.

---
 rtl/condicionador_pkg.sv | 13 +
 rtl/debounce_bit.sv | 34 +++
 rtl/condicionador_botoes.sv | 60 ++++++
 tb/tb_condicionador_botoes.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/condicionador_pkg.sv
// condicionador_pkg: shared FSM states, defaults and the one-hot test used by the button conditioner
package condicionador_pkg;
  localparam int NUM_BOTOES_PADRAO = 4;
  localparam int LARGURA_MAX = 32;
  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    AVALIA        = 2'd1,
    ESPERA_SOLTAR = 2'd2
  } estado_t;
  function automatic logic um_bit_ativo(input logic [LARGURA_MAX-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus level debouncer for one button line (debouncer kept only with CONDICIONADOR_DEBOUNCE_EN)
module debounce_bit #(
  parameter int DEBOUNCE_CICLOS = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic estavel
);
  logic [1:0] sinc;
  // bring the asynchronous level into the clock domain
  always_ff @(posedge clock or negedge reset)
    if (!reset) sinc <= '0;
    else sinc <= {sinc[0], entrada};
`ifdef CONDICIONADOR_DEBOUNCE_EN
  localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS - 1);
  logic [7:0] contagem;
  // accept a new level only after DEBOUNCE_CICLOS consecutive differing samples
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      contagem <= '0;
      estavel <= 1'b0;
    end else if (sinc[1] == estavel) contagem <= '0;
    else if (contagem == LIMITE) begin
      contagem <= '0;
      estavel <= sinc[1];
    end else contagem <= contagem + 8'd1;
`else
  // without debouncing the stable level is one register behind the synchronizer
  always_ff @(posedge clock or negedge reset)
    if (!reset) estavel <= 1'b0;
    else estavel <= sinc[1];
`endif
endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: turns raw buttons into one validated play pulse per press (debouncer enabled by CONDICIONADOR_DEBOUNCE_EN)
module condicionador_botoes
  import condicionador_pkg::*;
#(
  parameter int NUM_BOTOES = NUM_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic [NUM_BOTOES-1:0] botoes_in,
  output logic                  jogada,
  output logic [NUM_BOTOES-1:0] jogada_codigo,
  output logic                  jogada_invalida,
  output logic                  db_tem_jogada,
  output logic [1:0]            db_estado
);
  estado_t estado, proximo;
  logic [NUM_BOTOES-1:0] estavel, amostra, codigo;
  logic valido;
  for (genvar g = 0; g < NUM_BOTOES; g++) begin : g_linha
    debounce_bit #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db (
      .clock(clock),
      .reset(reset),
      .entrada(botoes_in[g]),
      .estavel(estavel[g])
    );
  end
  assign valido = um_bit_ativo(LARGURA_MAX'(amostra));
  // state register; the press vector is frozen on the edge that leaves OCIOSO so a quick release cannot change the verdict
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado <= OCIOSO;
      amostra <= '0;
      codigo <= '0;
    end else begin
      estado <= proximo;
      if (estado == OCIOSO) amostra <= estavel;
      if (jogada) codigo <= amostra;
    end
  // next state and single-cycle verdict pulses
  always_comb begin
    proximo = estado;
    jogada = 1'b0;
    jogada_invalida = 1'b0;
    case (estado)
      OCIOSO:        proximo = |estavel ? AVALIA : OCIOSO;
      AVALIA: begin
        proximo = ESPERA_SOLTAR;
        jogada = valido && habilita;
        jogada_invalida = !valido;
      end
      ESPERA_SOLTAR: proximo = |estavel ? ESPERA_SOLTAR : OCIOSO;
      default:       proximo = OCIOSO;
    endcase
  end
  assign jogada_codigo = jogada ? amostra : codigo;
  assign db_tem_jogada = |estavel;
  assign db_estado = estado;
endmodule

// File: tb/tb_condicionador_botoes.sv
// tb_condicionador_botoes: directed vector bench for condicionador_botoes
module tb_condicionador_botoes;
  localparam int DEB = 3;
`ifdef CONDICIONADOR_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
  localparam int J_G = 0;
  localparam int T_G = 0;
  localparam logic [3:0] COD_G = 4'b0100;
`else
  localparam int LAT = 3;
  localparam int J_G = 1;
  localparam int T_G = 1;
  localparam logic [3:0] COD_G = 4'b0010;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic habilita = 1'b1;
  logic [3:0] botoes_in = 4'b0001;
  logic jogada, jogada_invalida, db_tem_jogada;
  logic [3:0] jogada_codigo;
  logic [1:0] db_estado;
  int cyc = 0;
  int cnt_j = 0, cnt_i = 0, cnt_t = 0, overlap = 0, pulso_cyc = 0;
  logic [3:0] cod_pulso = '0;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic hab;
    logic [3:0] bot;
    int hold;
    int nj;
    int ni;
    logic [3:0] cod;
    int tem;
  } vetor_t;
  vetor_t tab[7];

  condicionador_botoes #(.NUM_BOTOES(4), .DEBOUNCE_CICLOS(DEB)) dut (
    .clock(clock),
    .reset(reset),
    .habilita(habilita),
    .botoes_in(botoes_in),
    .jogada(jogada),
    .jogada_codigo(jogada_codigo),
    .jogada_invalida(jogada_invalida),
    .db_tem_jogada(db_tem_jogada),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (jogada) begin
      cnt_j = cnt_j + 1;
      cod_pulso = jogada_codigo;
    end
    if (jogada_invalida) cnt_i = cnt_i + 1;
    if (jogada || jogada_invalida) pulso_cyc = cyc;
    if (db_tem_jogada) cnt_t = cnt_t + 1;
    if (jogada && jogada_invalida) overlap = overlap + 1;
  end

  task automatic chk(input string nome, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  task automatic aplica(input int idx, input vetor_t v);
    int bj, bi, bt, t0;
    @(negedge clock);
    bj = cnt_j; bi = cnt_i; bt = cnt_t;
    habilita = v.hab;
    botoes_in = v.bot;
    t0 = cyc;
    repeat (v.hold) @(negedge clock);
    botoes_in = '0;
    repeat (20) @(negedge clock);
    chk($sformatf("v%0d jogadas", idx), cnt_j - bj, v.nj);
    chk($sformatf("v%0d invalidas", idx), cnt_i - bi, v.ni);
    chk($sformatf("v%0d codigo", idx), int'(jogada_codigo), int'(v.cod));
    chk($sformatf("v%0d tem_jogada", idx), int'(cnt_t > bt), v.tem);
    if (v.nj + v.ni > 0) chk($sformatf("v%0d latencia", idx), pulso_cyc - t0 - 1, LAT);
    if (v.nj > 0) chk($sformatf("v%0d codigo_pulso", idx), int'(cod_pulso), int'(v.cod));
  endtask

  initial begin
    int bj, bi, t0;
    tab[0] = '{1'b1, 4'b0100, 5, 1, 0, 4'b0100, 1};
    tab[1] = '{1'b1, 4'b0011, 10, 0, 1, 4'b0100, 1};
    tab[2] = '{1'b1, 4'b0010, 2, J_G, 0, COD_G, T_G};
    tab[3] = '{1'b0, 4'b0001, 6, 0, 0, COD_G, 1};
    tab[4] = '{1'b1, 4'b0001, 6, 1, 0, 4'b0001, 1};
    tab[5] = '{1'b1, 4'b1100, 8, 0, 1, 4'b0001, 1};
    tab[6] = '{1'b1, 4'b1000, DEB, 1, 0, 4'b1000, 1};

    repeat (2) @(negedge clock);
    chk("reset saidas", int'({jogada, jogada_invalida, jogada_codigo, db_tem_jogada, db_estado}), 0);
    bj = cnt_j;
    reset = 1'b1;
    t0 = cyc;
    repeat (20) @(negedge clock);
    chk("pos_reset jogadas", cnt_j - bj, 1);
    chk("pos_reset latencia", pulso_cyc - t0 - 1, LAT);
    chk("pos_reset codigo", int'(cod_pulso), 1);
    botoes_in = '0;
    repeat (20) @(negedge clock);

    for (int i = 0; i < 7; i++) aplica(i, tab[i]);

    habilita = 1'b1;
    bj = cnt_j; bi = cnt_i;
    botoes_in = 4'b1000;
    t0 = cyc;
    repeat (20) @(negedge clock);
    botoes_in = 4'b1001;
    repeat (30) @(negedge clock);
    botoes_in = '0;
    repeat (20) @(negedge clock);
    chk("segura_soma jogadas", cnt_j - bj, 1);
    chk("segura_soma invalidas", cnt_i - bi, 0);
    chk("segura_soma latencia", pulso_cyc - t0 - 1, LAT);
    chk("segura_soma codigo", int'(jogada_codigo), 8);

    botoes_in = 4'b0100;
    repeat (12) @(negedge clock);
    chk("meio_reset estado_antes", int'(db_estado), 2);
    chk("meio_reset codigo_antes", int'(jogada_codigo), 4);
    reset = 1'b0;
    #1;
    chk("meio_reset estado", int'(db_estado), 0);
    chk("meio_reset codigo", int'(jogada_codigo), 0);
    chk("meio_reset tem", int'(db_tem_jogada), 0);
    @(negedge clock);
    bj = cnt_j;
    reset = 1'b1;
    t0 = cyc;
    repeat (20) @(negedge clock);
    botoes_in = '0;
    repeat (20) @(negedge clock);
    chk("meio_reset jogadas", cnt_j - bj, 1);
    chk("meio_reset latencia", pulso_cyc - t0 - 1, LAT);
    chk("meio_reset codigo_pulso", int'(cod_pulso), 4);
    chk("sem_sobreposicao", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
